ws2812_rx: RTL and testbench
============================

# ws2812_rx

Serial receiver for the WS2812 single-wire protocol: the inverse of `neopixel_controller`. It samples a raw WS2812 data line, classifies each high pulse as a 0 or 1 bit by width, and assembles MSB-first 24-bit pixel words indexed by position in the frame. It detects the latch gap as end of frame and flags malformed timing. It sits beside the strip driver as a loopback checker on `ws2812_dout`, and as a capture port for an external WS2812 source feeding the texture path.

## Interface

Parameters:
- `CLK_HZ`, 100_000_000, system clock frequency (documentation only; thresholds below are in cycles).
- `BITS_PER_PIXEL`, 24, bits per pixel word.
- `PX_COUNT_WIDTH`, 6, width of `px_idx`.
- `PX_NUM`, 52, maximum pixels accepted per frame.
- `MIN_HIGH`, 20, high pulses shorter than this many cycles are glitches.
- `BIT_THRESH`, 60, high width ≥ this decodes as 1, otherwise 0.
- `MAX_HIGH`, 120, high width reaching this is a stuck-high error.
- `LATCH_CYCLES`, 5000, low time ending a frame (50 µs).

Ports:
- `clk` in 1: system clock. One clock domain; all logic runs on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `din` in 1: raw WS2812 line, asynchronous to `clk`.
- `pixel` out `BITS_PER_PIXEL`: last completed pixel word, G-R-B order as received, MSB first.
- `px_idx` out `PX_COUNT_WIDTH`: index of `pixel` within the current frame.
- `px_valid` out 1: one-cycle strobe; `pixel` and `px_idx` are valid.
- `frame_done` out 1: one-cycle strobe at detection of the latch gap.
- `frame_px_count` out `PX_COUNT_WIDTH+1`: number of complete pixels in the frame; valid with `frame_done`.
- `err` out 1: one-cycle strobe on a protocol error.
- `err_code` out 2: cause of the last error, held until the next error.
  - 1 = glitch.
  - 2 = stuck high.
  - 3 = partial pixel or overflow.
- `busy` out 1: high in states HIGH and LOW.

## Operation

- **Input conditioning.** `din` passes through a 2-flop synchronizer, then a registered copy is used for edge detection.
- **Counters.**
  - Cycle counter `cnt`: `$clog2(LATCH_CYCLES+1)` bits, saturating.
  - Bit counter: 0..`BITS_PER_PIXEL-1`.
  - Pixel counter: 0..`PX_NUM`.
- **States:**
  - SYNC: entered on reset. Waits for the line to stay low for `LATCH_CYCLES` consecutive cycles; any high sample clears `cnt`. When the gap is met, go to IDLE. No `frame_done` is issued.
  - IDLE: armed, line low. On a rising edge, clear `cnt` and go to HIGH.
  - HIGH: counts cycles while the line is high.
    - If `cnt` reaches `MAX_HIGH`: raise `err` with code 2 and go to SYNC.
    - On a falling edge with `cnt < MIN_HIGH`: raise `err` with code 1 and go to SYNC.
    - Otherwise shift bit (`cnt ≥ BIT_THRESH`) into the LSB of the shift register, increment the bit counter, clear `cnt`, and go to LOW.
    - When the bit counter wraps from 23 to 0 and the pixel counter < `PX_NUM`: load `pixel`, drive `px_idx` = pixel counter, pulse `px_valid`, then increment the pixel counter.
    - When the bit counter wraps and the pixel counter = `PX_NUM`: no `px_valid`; raise `err` with code 3 once per frame.
  - LOW: counts cycles while the line is low.
    - On a rising edge: clear `cnt` and go to HIGH.
    - If `cnt` reaches `LATCH_CYCLES`: pulse `frame_done` with `frame_px_count` = pixel counter. If the bit counter ≠ 0, also raise `err` with code 3. Then clear the bit and pixel counters and go to IDLE.
- **Error paths.** Every transition to SYNC clears the bit and pixel counters. No `frame_done` is issued for an aborted frame.
- **Simultaneous events.**
  - If a falling edge arrives in the same cycle that `cnt` reaches `MAX_HIGH`, stuck-high wins.
  - Overflow and partial-pixel errors in the same frame report code 3 once at overflow and once at the latch gap.

## Timing

- **Reset values:**
  - `pixel` = 0, `px_idx` = 0, `frame_px_count` = 0, `err_code` = 0.
  - All strobes 0, `busy` = 0.
  - State = SYNC, all counters 0.
- **Reset mid-frame.** Reset asserted at any point returns everything to these values on the next edge. No strobes fire during or in the cycle after reset.
- **Latency.**
  - Let cycle N be the first `clk` edge that samples `din` low after the 24th bit's high pulse. `px_valid` is high in cycle N+3 only.
  - `frame_done` is high exactly `LATCH_CYCLES` cycles after the LOW entry, plus 3.
- **Pulse width measurement.** Measured widths include ±1 cycle of synchronizer uncertainty; thresholds are inclusive as stated.
- **Strobe overlap.** `px_valid` and `frame_done` are never high in the same cycle.
- **Throughput.** Minimum bit period accepted: `MIN_HIGH` + 2 cycles.

## Test plan

- **Single pixel.** Reset, then 5000 low cycles, then pixel 0xA53C0F (0 = 40 high / 85 low, 1 = 80 high / 45 low), then 5000 low. Expect:
  - one `px_valid` with `pixel` = 0xA53C0F and `px_idx` = 0;
  - `frame_done` with `frame_px_count` = 1;
  - `err` never asserted.
- **Early data after reset.** Bits start 100 cycles after reset is released. Expect no `px_valid`. Once the line then stays low for 5000 cycles, a following valid pixel decodes correctly with `px_idx` = 0.
- **Glitch and stuck high.** Expect:
  - a 10-cycle high gives `err` with code 1 and no `px_valid`;
  - a high held for 130 cycles gives `err` in the cycle `cnt` hits 120, with code 2.
  - In both cases the state returns to SYNC.
- **Overflow.** Send 53 pixels, where each pixel's value equals its index. Expect:
  - 52 `px_valid` strobes with `px_idx` 0..51 and matching data;
  - `err` code 3 on the 53rd pixel;
  - `frame_px_count` = 52.
- **Partial pixel.** Send 2 pixels plus 12 bits, then the latch gap. Expect `frame_done` with count 2 and `err` code 3 in the same cycle.
- **Reset mid-pixel.** Assert `reset_n` low for 1 cycle after bit 10. Expect:
  - all outputs return to their reset values;
  - the remaining bits are ignored until a 5000-cycle gap;
  - the next frame decodes from `px_idx` 0.

Source files
------------

// File: rtl/ws2812_rx.sv
// ws2812_rx: decodes a raw WS2812 line into MSB-first pixel words with frame and error strobes.
module ws2812_rx #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int BITS_PER_PIXEL = 24,
  parameter int PX_COUNT_WIDTH = 6,
  parameter int PX_NUM         = 52,
  parameter int MIN_HIGH       = 20,
  parameter int BIT_THRESH     = 60,
  parameter int MAX_HIGH       = 120,
  parameter int LATCH_CYCLES   = 5000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      din,
  output logic [BITS_PER_PIXEL-1:0] pixel,
  output logic [PX_COUNT_WIDTH-1:0] px_idx,
  output logic                      px_valid,
  output logic                      frame_done,
  output logic [PX_COUNT_WIDTH:0]   frame_px_count,
  output logic                      err,
  output logic [1:0]                err_code,
  output logic                      busy
);
  localparam int cw = $clog2(LATCH_CYCLES + 1);
  localparam int bw = $clog2(BITS_PER_PIXEL);
  localparam int pw = PX_COUNT_WIDTH + 1;
  // CLK_HZ only documents the cycle thresholds; it folds to zero here.
  localparam logic [cw-1:0] c_lat = cw'(LATCH_CYCLES - 1 + 0 * CLK_HZ);
  localparam logic [cw-1:0] c_min = cw'(MIN_HIGH);
  localparam logic [cw-1:0] c_thr = cw'(BIT_THRESH);
  localparam logic [cw-1:0] c_max = cw'(MAX_HIGH);
  localparam logic [bw-1:0] b_last = bw'(BITS_PER_PIXEL - 1);
  localparam logic [pw-1:0] p_max = pw'(PX_NUM);
  localparam logic [1:0] st_sync = 2'd0;
  localparam logic [1:0] st_idle = 2'd1;
  localparam logic [1:0] st_high = 2'd2;
  localparam logic [1:0] st_low  = 2'd3;
  logic s0, s1, d_prev, ovf;
  logic [1:0] state;
  logic [cw-1:0] cnt;
  logic [bw-1:0] bit_cnt;
  logic [pw-1:0] px_cnt;
  logic [BITS_PER_PIXEL-1:0] shift, word;
  logic rise, fall, abort, last_bit;
  always_comb begin
    rise = s1 & ~d_prev;
    fall = ~s1 & d_prev;
    abort = cnt == c_max || (fall && cnt < c_min);
    last_bit = bit_cnt == b_last;
    word = {shift[BITS_PER_PIXEL-2:0], cnt >= c_thr};
  end
  assign busy = state == st_high || state == st_low;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      d_prev <= 1'b0;
      state <= st_sync;
      cnt <= '0;
      bit_cnt <= '0;
      px_cnt <= '0;
      shift <= '0;
      ovf <= 1'b0;
      pixel <= '0;
      px_idx <= '0;
      frame_px_count <= '0;
      px_valid <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'd0;
    end else begin
      s0 <= din;
      s1 <= s0;
      d_prev <= s1;
      px_valid <= 1'b0;
      frame_done <= 1'b0;
      err <= 1'b0;
      case (state)
        st_sync: begin
          cnt <= s1 ? '0 : cnt + 1'b1;
          if (!s1 && cnt == c_lat) begin
            cnt <= '0;
            state <= st_idle;
          end
        end
        st_idle: if (rise) begin
          cnt <= '0;
          state <= st_high;
        end
        st_high: if (abort) begin
          // stuck-high is tested first so it wins over a coincident falling edge
          err <= 1'b1;
          err_code <= cnt == c_max ? 2'd2 : 2'd1;
          state <= st_sync;
          cnt <= '0;
          bit_cnt <= '0;
          px_cnt <= '0;
          ovf <= 1'b0;
        end else if (fall) begin
          shift <= word;
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          cnt <= '0;
          state <= st_low;
          if (last_bit && px_cnt < p_max) begin
            pixel <= word;
            px_idx <= px_cnt[PX_COUNT_WIDTH-1:0];
            px_valid <= 1'b1;
            px_cnt <= px_cnt + 1'b1;
          end else if (last_bit && !ovf) begin
            ovf <= 1'b1;
            err <= 1'b1;
            err_code <= 2'd3;
          end
        end else cnt <= cnt + 1'b1;
        st_low: if (rise) begin
          cnt <= '0;
          state <= st_high;
        end else if (cnt == c_lat) begin
          frame_done <= 1'b1;
          frame_px_count <= px_cnt;
          if (bit_cnt != '0) begin
            err <= 1'b1;
            err_code <= 2'd3;
          end
          bit_cnt <= '0;
          px_cnt <= '0;
          ovf <= 1'b0;
          cnt <= '0;
          state <= st_idle;
        end else cnt <= cnt + 1'b1;
        default: state <= st_sync;
      endcase
    end
  end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: randomized WS2812 frames checked against a pulse-level model of the receiver.
module tb_ws2812_rx;
  localparam int MINH = 4, THR = 12, MAXH = 24, LAT = 200, NPX = 52, GAP = 260;
  logic clk = 1'b0, reset_n = 1'b0, din = 1'b0;
  logic [23:0] pixel;
  logic [5:0] px_idx;
  logic px_valid, frame_done, err, busy;
  logic [6:0] frame_px_count;
  logic [1:0] err_code;

  ws2812_rx #(
    .MIN_HIGH(MINH), .BIT_THRESH(THR), .MAX_HIGH(MAXH), .LATCH_CYCLES(LAT), .PX_NUM(NPX)
  ) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .pixel(pixel), .px_idx(px_idx),
    .px_valid(px_valid), .frame_done(frame_done), .frame_px_count(frame_px_count),
    .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [23:0] v; int idx; int lo; int hi;} px_t;
  typedef struct {int code; int lo; int hi;} er_t;
  typedef struct {int n; bit partial; int lo; int hi;} fr_t;
  px_t px_q[$];
  er_t er_q[$];
  fr_t fr_q[$];

  int checks = 0, failures = 0;
  bit synced = 0, in_frame = 0, ovf = 0;
  int nbits = 0, npx = 0, last_fall = 0;
  logic [23:0] sh = '0;
  int px_seen = 0, err_seen = 0, fr_seen = 0, last_idx = 0, last_fc = 0;
  logic [23:0] last_pixel = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(string name, int act, int exp);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Compare every observed strobe against the model's queued expectations.
  always @(negedge clk) begin
    px_t pe;
    er_t ee;
    fr_t fe;
    if (px_valid === 1'b1 && frame_done === 1'b1) fail_now("strobe_overlap", 1, 0);
    if (px_valid === 1'b1) begin
      px_seen++;
      last_pixel = pixel;
      last_idx = px_idx;
      if (px_q.size() == 0) fail_now("px_unexpected", px_idx, -1);
      else begin
        pe = px_q.pop_front();
        check("px_data", pixel, pe.v);
        check("px_idx", px_idx, pe.idx);
        check("px_time", cyc, (cyc >= pe.lo && cyc <= pe.hi) ? cyc : pe.lo);
      end
    end
    if (err === 1'b1) begin
      err_seen++;
      if (er_q.size() == 0) fail_now("err_unexpected", err_code, 0);
      else begin
        ee = er_q.pop_front();
        check("err_code", err_code, ee.code);
        check("err_time", cyc, (cyc >= ee.lo && cyc <= ee.hi) ? cyc : ee.lo);
      end
    end
    if (frame_done === 1'b1) begin
      fr_seen++;
      last_fc = frame_px_count;
      if (fr_q.size() == 0) fail_now("frame_unexpected", frame_px_count, -1);
      else begin
        fe = fr_q.pop_front();
        check("frame_count", frame_px_count, fe.n);
        check("frame_time", cyc, (cyc >= fe.lo && cyc <= fe.hi) ? cyc : fe.lo);
        if (fe.partial) check("partial_err_same_cycle", err, 1);
      end
    end
    if (px_q.size() > 0 && cyc > px_q[0].hi) begin
      fail_now("px_missing", px_q[0].idx, cyc);
      void'(px_q.pop_front());
    end
    if (er_q.size() > 0 && cyc > er_q[0].hi) begin
      fail_now("err_missing", er_q[0].code, cyc);
      void'(er_q.pop_front());
    end
    if (fr_q.size() > 0 && cyc > fr_q[0].hi) begin
      fail_now("frame_missing", fr_q[0].n, cyc);
      void'(fr_q.pop_front());
    end
  end

  task automatic wait_cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic desync();
    synced = 0;
    in_frame = 0;
    nbits = 0;
    npx = 0;
    ovf = 0;
  endtask

  task automatic send_bit(bit b, int h, int l);
    din = 1'b1;
    wait_cyc(h);
    check("busy_in_pulse", busy, synced);
    din = 1'b0;
    last_fall = cyc;
    if (synced) begin
      in_frame = 1;
      sh = {sh[22:0], b};
      nbits++;
      if (nbits == 24) begin
        nbits = 0;
        if (npx < NPX) begin
          px_q.push_back('{sh, npx, last_fall + 3, last_fall + 3});
          npx++;
        end else if (!ovf) begin
          ovf = 1;
          er_q.push_back('{3, last_fall + 1, last_fall + 5});
        end
      end
    end
    wait_cyc(l);
  endtask

  task automatic send_rand_bit();
    bit b;
    b = 1'($urandom_range(1, 0));
    send_bit(b, b ? int'($urandom_range(21, 15)) : int'($urandom_range(10, 6)), int'($urandom_range(8, 3)));
  endtask

  task automatic send_px(logic [23:0] v, int mode);
    for (int i = 23; i >= 0; i--) begin
      bit b;
      int h, l;
      b = v[i];
      if (mode == 0) begin
        h = b ? 18 : 8;
        l = b ? 5 : 9;
      end else if (mode == 1) begin
        h = b ? int'($urandom_range(21, 15)) : int'($urandom_range(10, 6));
        l = int'($urandom_range(8, 3));
      end else begin
        h = b ? 15 : 6;
        l = 3;
      end
      send_bit(b, h, l);
    end
  endtask

  task automatic gap();
    din = 1'b0;
    if (synced && in_frame) begin
      fr_q.push_back('{npx, (nbits != 0), last_fall + LAT, last_fall + LAT + 10});
      if (nbits != 0) er_q.push_back('{3, last_fall + LAT, last_fall + LAT + 10});
      nbits = 0;
      npx = 0;
      ovf = 0;
      in_frame = 0;
    end else synced = 1;
    wait_cyc(GAP);
  endtask

  task automatic glitch();
    din = 1'b1;
    wait_cyc(2);
    din = 1'b0;
    if (synced) er_q.push_back('{1, cyc + 1, cyc + 5});
    desync();
    wait_cyc(6);
  endtask

  task automatic stuck();
    if (synced) er_q.push_back('{2, cyc + MAXH, cyc + MAXH + 6});
    desync();
    din = 1'b1;
    wait_cyc(40);
    din = 1'b0;
    wait_cyc(6);
  endtask

  task automatic check_reset_values();
    check("rst_pixel", pixel, 0);
    check("rst_px_idx", px_idx, 0);
    check("rst_frame_px_count", frame_px_count, 0);
    check("rst_err_code", err_code, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", {px_valid, frame_done, err}, 0);
  endtask

  task automatic do_reset();
    din = 1'b0;
    reset_n = 1'b0;
    wait_cyc(1);
    reset_n = 1'b1;
    px_q.delete();
    er_q.delete();
    fr_q.delete();
    desync();
    check_reset_values();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] v;
    int base, n;
    wait_cyc(2);
    reset_n = 1'b1;
    check_reset_values();
    // single known pixel
    gap();
    send_px(24'hA53C0F, 0);
    gap();
    check("single_pixel", last_pixel, 24'hA53C0F);
    check("single_idx", last_idx, 0);
    check("single_fc", last_fc, 1);
    check("single_px_seen", px_seen, 1);
    check("single_no_err", err_seen, 0);
    // data arriving before the line has been seen idle
    do_reset();
    wait_cyc(100);
    send_px(24'($urandom), 1);
    gap();
    v = 24'($urandom);
    send_px(v, 1);
    gap();
    check("early_px_seen", px_seen, 2);
    check("early_idx", last_idx, 0);
    check("early_pixel", last_pixel, v);
    // glitches from idle and mid-frame, then stuck high
    glitch();
    check("glitch_code", err_code, 1);
    gap();
    repeat (8) send_rand_bit();
    glitch();
    check("glitch_mid_code", err_code, 1);
    gap();
    stuck();
    check("stuck_code", err_code, 2);
    check("stuck_no_px", px_seen, 2);
    gap();
    // overflow: 53 pixels valued by index
    base = px_seen;
    for (int i = 0; i < 53; i++) send_px(24'(i), 2);
    gap();
    check("ovf_px_count", px_seen - base, 52);
    check("ovf_last_pixel", last_pixel, 24'd51);
    check("ovf_fc", last_fc, 52);
    check("ovf_err_code", err_code, 3);
    // partial pixel at latch gap
    repeat (2) send_px(24'($urandom), 1);
    repeat (12) send_rand_bit();
    gap();
    check("partial_fc", last_fc, 2);
    check("partial_code", err_code, 3);
    // random frames
    repeat (4) begin
      n = int'($urandom_range(4, 1));
      for (int i = 0; i < n; i++) send_px(24'($urandom), 1);
      gap();
      check("rand_fc", last_fc, n);
    end
    // reset in the middle of a pixel
    repeat (10) send_rand_bit();
    do_reset();
    repeat (14) send_rand_bit();
    gap();
    v = 24'($urandom);
    send_px(v, 1);
    gap();
    check("after_reset_idx", last_idx, 0);
    check("after_reset_pixel", last_pixel, v);
    check("after_reset_fc", last_fc, 1);
    wait_cyc(20);
    check("pending_px", px_q.size(), 0);
    check("pending_err", er_q.size(), 0);
    check("pending_frame", fr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
